// File: rtl/enemy_hit_detect.sv
// enemy_hit_detect: per-frame bullet vs enemy-formation collision scan with alive bitmap and score
module enemy_hit_detect #(
    parameter int ROWS      = 4,
    parameter int COLS      = 8,
    parameter int ENEMY_W   = 32,
    parameter int ENEMY_H   = 24,
    parameter int SPACING_X = 48,
    parameter int SPACING_Y = 40,
    parameter int BULLET_W  = 4,
    parameter int BULLET_H  = 12,
    parameter int POINTS    = 10,
    parameter int SCORE_W   = 16,
    localparam int N        = ROWS * COLS,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               fsync,
    input  logic               bullet_live,
    input  logic [11:0]        bullet_center_x,
    input  logic [11:0]        bullet_top_y,
    input  logic [11:0]        formation_x,
    input  logic [11:0]        formation_y,
    input  logic               wave_reload,
    output logic [N-1:0]       alive_mask,
    output logic               bullet_hit,
    output logic [IW-1:0]      hit_index,
    output logic [SCORE_W-1:0] score,
    output logic               all_clear,
    output logic               busy
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

    state_t state, state_nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic signed [13:0] bx, by, fx, fy;
    logic signed [13:0] cell_l, cell_r, cell_t, cell_b;
    logic signed [13:0] box_l, box_r, box_t, box_b;
    logic overlap, start, last;
    logic [SCORE_W:0] score_sum;

    // Geometry of the cell under evaluation against the latched bullet box, in 14-bit signed
    always_comb begin
        cell_l    = fx + $signed(14'(int'(col) * SPACING_X));
        cell_r    = cell_l + $signed(14'(ENEMY_W - 1));
        cell_t    = fy + $signed(14'(int'(row) * SPACING_Y));
        cell_b    = cell_t + $signed(14'(ENEMY_H - 1));
        box_l     = bx - $signed(14'(BULLET_W / 2));
        box_r     = bx + $signed(14'(BULLET_W / 2));
        box_t     = by;
        box_b     = by + $signed(14'(BULLET_H));
        overlap   = alive_mask[idx] && (box_l <= cell_r) && (box_r >= cell_l) &&
                    (box_t <= cell_b) && (box_b >= cell_t);
        start     = (state == IDLE) && fsync && bullet_live && (|alive_mask);
        last      = (idx == IW'(N - 1));
        score_sum = {1'b0, score} + (SCORE_W + 1)'(POINTS);
    end

    // Next-state: reload wins, a scan ends on the first hit or after the last cell
    always_comb begin
        state_nxt = state;
        if (wave_reload)
            state_nxt = IDLE;
        else if (state == IDLE)
            state_nxt = start ? SCAN : IDLE;
        else if (state == SCAN)
            state_nxt = overlap ? HIT : (last ? IDLE : SCAN);
        else
            state_nxt = IDLE;
    end

    // State, scan cursor and the frame's bullet/formation snapshot
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            col   <= '0;
            row   <= '0;
            bx    <= '0;
            by    <= '0;
            fx    <= '0;
            fy    <= '0;
        end else begin
            state <= state_nxt;
            if (start && !wave_reload) begin
                idx <= '0;
                col <= '0;
                row <= '0;
                bx  <= {{2{bullet_center_x[11]}}, bullet_center_x};
                by  <= {{2{bullet_top_y[11]}}, bullet_top_y};
                fx  <= {{2{formation_x[11]}}, formation_x};
                fy  <= {{2{formation_y[11]}}, formation_y};
            end else if (state == SCAN && !overlap && !last) begin
                idx <= idx + 1'b1;
                col <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
                row <= (col == CW'(COLS - 1)) ? row + 1'b1 : row;
            end
        end
    end

    // Kill bookkeeping: alive bitmap, saturating score and index of the last kill
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            alive_mask <= '1;
            score      <= '0;
            hit_index  <= '0;
        end else if (wave_reload) begin
            alive_mask <= '1;
        end else begin
            if (state == SCAN && overlap)
                hit_index <= idx;
            if (state == HIT) begin
                alive_mask[idx] <= 1'b0;
                score           <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
        end
    end

    assign bullet_hit = (state == HIT) && !wave_reload;
    assign busy       = (state != IDLE);
    assign all_clear  = ~|alive_mask;
endmodule

// File: tb/tb_enemy_hit_detect.sv
// tb_enemy_hit_detect: directed stimulus with a frame-level reference model checked every cycle
module tb_enemy_hit_detect;
    localparam int ROWS = 4, COLS = 8, N = ROWS * COLS;

    logic        pixel_clk = 0;
    logic        rst = 1, fsync = 0, bullet_live = 0, wave_reload = 0;
    logic [11:0] bullet_center_x = 0, bullet_top_y = 0, formation_x = 0, formation_y = 0;
    logic [N-1:0] alive_mask;
    logic        bullet_hit, all_clear, busy;
    logic [4:0]  hit_index;
    logic [15:0] score;

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0;

    logic [N-1:0] m_alive;
    int m_score, m_hit_index, m_cnt, m_k;

    enemy_hit_detect dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .bullet_live(bullet_live),
        .bullet_center_x(bullet_center_x), .bullet_top_y(bullet_top_y),
        .formation_x(formation_x), .formation_y(formation_y), .wave_reload(wave_reload),
        .alive_mask(alive_mask), .bullet_hit(bullet_hit), .hit_index(hit_index),
        .score(score), .all_clear(all_clear), .busy(busy)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First alive cell whose box overlaps the bullet box, scanning in index order; -1 if none
    function automatic int find_k(input logic [N-1:0] alive, input int bx, input int by,
                                  input int fx, input int fy);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int l = fx + c * 48, t = fy + r * 40;
                if (alive[r*COLS+c] && bx - 2 <= l + 31 && bx + 2 >= l && by <= t + 23 && by + 12 >= t)
                    return r * COLS + c;
            end
        return -1;
    endfunction

    // Frame-level model: an accepted fsync yields k+2 busy cycles ending in a kill, or N idle-ending cycles
    always @(posedge pixel_clk) begin
        if (rst) begin
            m_alive <= '1; m_score <= 0; m_hit_index <= 0; m_cnt <= 0; m_k <= -1;
        end else if (wave_reload) begin
            m_alive <= '1; m_cnt <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_k >= 0 && m_cnt == 2) m_hit_index <= m_k;
            if (m_k >= 0 && m_cnt == 1) begin
                m_alive[m_k] <= 1'b0;
                m_score <= (m_score + 10 > 65535) ? 65535 : m_score + 10;
            end
        end else if (fsync && bullet_live && m_alive != 0) begin
            m_k <= find_k(m_alive, int'($signed(bullet_center_x)), int'($signed(bullet_top_y)),
                          int'($signed(formation_x)), int'($signed(formation_y)));
            m_cnt <= (find_k(m_alive, int'($signed(bullet_center_x)), int'($signed(bullet_top_y)),
                             int'($signed(formation_x)), int'($signed(formation_y))) >= 0)
                     ? find_k(m_alive, int'($signed(bullet_center_x)), int'($signed(bullet_top_y)),
                              int'($signed(formation_x)), int'($signed(formation_y))) + 2 : N;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge pixel_clk) begin
        if (chk_en) begin
            chk("alive_mask", alive_mask, m_alive);
            chk("score", score, m_score);
            chk("busy", busy, m_cnt > 0);
            chk("bullet_hit", bullet_hit, m_cnt == 1 && m_k >= 0 && !wave_reload);
            chk("hit_index", hit_index, m_hit_index);
            chk("all_clear", all_clear, m_alive == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #2;
    endtask

    task automatic pulse_fsync();
        fsync = 1; tick(1); fsync = 0;
    endtask

    task automatic wait_hit();
        int n = 0;
        while (!bullet_hit && n < 40) begin tick(1); n++; end
        chk("wait_hit", bullet_hit, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin tick(1); n++; end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        int n;
        tick(2);
        chk_en = 1;
        rst = 0;
        chk("rst_alive", alive_mask, 32'hFFFF_FFFF);
        chk("rst_score", score, 0);
        chk("rst_all_clear", all_clear, 0);
        chk("rst_busy", busy, 0);

        formation_x = 100; formation_y = 50; bullet_live = 1;
        bullet_center_x = 116; bullet_top_y = 60;
        pulse_fsync();
        chk("t2_busy", busy, 1);
        tick(1);
        chk("t2_hit", bullet_hit, 1);
        chk("t2_index", hit_index, 0);
        tick(1);
        chk("t2_bit0", alive_mask[0], 0);
        chk("t2_score", score, 10);

        bullet_center_x = 180;
        pulse_fsync();
        tick(2);
        chk("t3_hit", bullet_hit, 1);
        chk("t3_index", hit_index, 1);
        tick(1);

        bullet_center_x = 188;
        pulse_fsync();
        n = 0;
        while (busy && n < 100) begin
            fsync = (n == 5);
            tick(1);
            n++;
        end
        fsync = 0;
        chk("t3_nohit_cycles", n, 32);
        chk("t3_nohit_score", score, 20);

        bullet_center_x = 116;
        pulse_fsync();
        wait_idle();
        chk("t4_dead_score", score, 20);
        bullet_top_y = 100;
        pulse_fsync();
        wait_hit();
        chk("t4_index", hit_index, 8);
        tick(1);
        chk("t4_score", score, 30);

        bullet_center_x = 188; bullet_top_y = 60;
        pulse_fsync();
        tick(3);
        rst = 1; tick(1); rst = 0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_score", score, 0);
        chk("rst_mid_alive", alive_mask, 32'hFFFF_FFFF);

        bullet_center_x = 116;
        for (int i = 0; i < 6553; i++) begin
            pulse_fsync();
            tick(2);
            wave_reload = 1; tick(1); wave_reload = 0;
        end
        chk("t5_preload", score, 65530);
        pulse_fsync();
        tick(2);
        chk("t5_sat", score, 65535);
        wave_reload = 1; tick(1); wave_reload = 0;
        pulse_fsync();
        tick(2);
        chk("t5_sat_hold", score, 65535);
        chk("t5_bit0", alive_mask[0], 0);

        wave_reload = 1; tick(1); wave_reload = 0;
        pulse_fsync();
        tick(1);
        wave_reload = 1;
        #1;
        chk("t6_reload_hit", bullet_hit, 0);
        tick(1);
        wave_reload = 0;
        chk("t6_alive", alive_mask, 32'hFFFF_FFFF);
        chk("t6_busy", busy, 0);
        bullet_live = 0;
        pulse_fsync();
        chk("t6_not_live", busy, 0);
        tick(1);

        bullet_live = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                bullet_center_x = 12'(116 + c * 48);
                bullet_top_y = 12'(60 + r * 40);
                pulse_fsync();
                wait_hit();
                chk("clear_index", hit_index, r * COLS + c);
                tick(1);
            end
        chk("all_clear", all_clear, 1);
        pulse_fsync();
        chk("all_clear_no_scan", busy, 0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
